// File: rtl/sleep_seq_if.sv
// Signal bundle between the CPU/bus side and the sleep sequencer.
// The master drives the request and wake inputs; the sequencer (slave) drives the gating outputs.
`timescale 1ns/1ps
interface sleep_seq_if #(
    parameter int IRQ_W = 4
);
    logic             wfi_req;
    logic             bus_idle;
    logic [IRQ_W-1:0] irq;
    logic [IRQ_W-1:0] irq_en;
    logic             pll_lock;
    logic             pll_gate;
    logic             core_hold;
    logic             wake;
    logic [31:0]      sleep_cnt;
    logic [2:0]       state;

    modport master (
        output wfi_req, bus_idle, irq, irq_en, pll_lock,
        input  pll_gate, core_hold, wake, sleep_cnt, state
    );

    modport slave (
        input  wfi_req, bus_idle, irq, irq_en, pll_lock,
        output pll_gate, core_hold, wake, sleep_cnt, state
    );
endinterface

// File: rtl/sleep_seq.sv
// WFI sleep sequencer: drains the bus, gates the PLL, and holds the core through relock on wake.
// Optional SLEEP_SEQ_LOCK_EN: leave RELOCK early on synchronised pll_lock (min 16-cycle hold, count is timeout).
`timescale 1ns/1ps
module sleep_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int DRAIN_CYCLES  = 16,
    parameter int RELOCK_CYCLES = 1024,
    parameter int IRQ_W         = 4
) (
    input  logic        clk_ref,
    input  logic        rst,
    sleep_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        GATED  = 3'd2,
        RELOCK = 3'd3,
        RESUME = 3'd4
    } state_t;

    localparam int DCNT_W = (DRAIN_CYCLES  > 1) ? $clog2(DRAIN_CYCLES)  : 1;
    localparam int RCNT_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RELOCK_CYCLES - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] wfi_sync;
    logic [IRQ_W-1:0]   irq_sync [SYNC_STAGES];
    logic [DCNT_W-1:0]  dcnt;
    logic [RCNT_W-1:0]  rcnt;
    logic               armed;
    logic               abort;
    logic               relock_done;
    logic               pll_gate_q, core_hold_q, wake_q;
    logic [31:0]        sleep_cnt_q;
    logic               wfi_s, pend;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            wfi_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) irq_sync[i] <= '0;
        end else begin
            wfi_sync    <= {wfi_sync[SYNC_STAGES-2:0], bus.wfi_req};
            irq_sync[0] <= bus.irq;
            for (int i = 1; i < SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
        end
    end

    assign wfi_s = wfi_sync[SYNC_STAGES-1];
    assign pend  = |(irq_sync[SYNC_STAGES-1] & bus.irq_en);

`ifdef SLEEP_SEQ_LOCK_EN
    logic [SYNC_STAGES-1:0] lock_sync;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) lock_sync <= '0;
        else     lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_lock};
    end

    // The counter limit still forces the exit if lock never arrives.
    assign relock_done = (rcnt == RCNT_LAST) ||
                         (lock_sync[SYNC_STAGES-1] && (32'(rcnt) >= 32'd15));
`else
    logic unused_pll_lock;
    assign unused_pll_lock = bus.pll_lock;
    assign relock_done     = (rcnt == RCNT_LAST);
`endif

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            RUN: begin
                if (wfi_s && armed) begin
                    if (pend) abort   = 1'b1;
                    else      state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend)                                   state_d = RESUME;
                else if (bus.bus_idle && dcnt == DCNT_LAST) state_d = GATED;
            end
            GATED:   if (pend) state_d = RELOCK;
            RELOCK:  if (relock_done) state_d = RESUME;
            RESUME:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs are registered from the next state so they change together with state.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            armed       <= 1'b1;
            dcnt        <= '0;
            rcnt        <= '0;
            pll_gate_q  <= 1'b0;
            core_hold_q <= 1'b0;
            wake_q      <= 1'b0;
            sleep_cnt_q <= '0;
        end else begin
            state_q <= state_d;

            if (!wfi_s)                                      armed <= 1'b1;
            else if (abort || (state_q == RUN && state_d != RUN)) armed <= 1'b0;

            if (state_q != DRAIN || state_d != DRAIN || !bus.bus_idle) dcnt <= '0;
            else                                                       dcnt <= dcnt + 1'b1;

            if (state_q != RELOCK || state_d != RELOCK) rcnt <= '0;
            else                                        rcnt <= rcnt + 1'b1;

            pll_gate_q  <= (state_d == GATED);
            core_hold_q <= (state_d != RUN);
            wake_q      <= (state_d == RESUME) || abort;

            if (state_q == GATED) sleep_cnt_q <= sat_inc(sleep_cnt_q);
        end
    end

    assign bus.pll_gate  = pll_gate_q;
    assign bus.core_hold = core_hold_q;
    assign bus.wake      = wake_q;
    assign bus.sleep_cnt = sleep_cnt_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_sleep_seq.sv
// Directed bench for sleep_seq: drain/gate timing, wake path, aborts, masking, saturation, async reset.
`timescale 1ns/1ps
module tb_sleep_seq;
    localparam int S  = 2;
    localparam int D  = 16;
    localparam int R  = 1024;
    localparam int IW = 4;

    logic clk_ref = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    sleep_seq_if #(.IRQ_W(IW)) sif();

    sleep_seq #(
        .SYNC_STAGES(S), .DRAIN_CYCLES(D), .RELOCK_CYCLES(R), .IRQ_W(IW)
    ) dut (
        .clk_ref (clk_ref),
        .rst     (rst),
        .bus     (sif.slave)
    );

    always #10 clk_ref = ~clk_ref;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_ref);
            #1;
        end
    endtask

    task automatic set_defaults;
        sif.wfi_req  = 1'b0;
        sif.bus_idle = 1'b1;
        sif.irq      = '0;
        sif.irq_en   = 4'b0001;
        sif.pll_lock = 1'b0;
    endtask

    task automatic do_reset;
        set_defaults();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        set_defaults();
        rst = 1'b1;
        tick(2);
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", sif.state); end
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL reset_pll_gate: got %b want 0", sif.pll_gate); end
        n_tests++; if (sif.core_hold !== 1'b0) begin n_fail++; $display("FAIL reset_core_hold: got %b want 0", sif.core_hold); end
        n_tests++; if (sif.wake !== 1'b0) begin n_fail++; $display("FAIL reset_wake: got %b want 0", sif.wake); end
        n_tests++; if (sif.sleep_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_sleep_cnt: got %0d want 0", sif.sleep_cnt); end
        rst = 1'b0;
        tick(3);
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL reset_idle_state: got %0d want 0", sif.state); end
    endtask

    task automatic test_wake_path;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S);
        n_tests++; if (sif.core_hold !== 1'b0) begin n_fail++; $display("FAIL hold_early: got %b want 0", sif.core_hold); end
        tick(1);
        n_tests++; if (sif.core_hold !== 1'b1) begin n_fail++; $display("FAIL hold_rise: got %b want 1", sif.core_hold); end
        n_tests++; if (sif.state !== 3'd1) begin n_fail++; $display("FAIL drain_state: got %0d want 1", sif.state); end
        tick(D - 1);
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL gate_early: got %b want 0", sif.pll_gate); end
        tick(1);
        n_tests++; if (sif.pll_gate !== 1'b1) begin n_fail++; $display("FAIL gate_rise: got %b want 1", sif.pll_gate); end
        n_tests++; if (sif.state !== 3'd2) begin n_fail++; $display("FAIL gated_state: got %0d want 2", sif.state); end
        sif.wfi_req = 1'b0;
        tick(100);
        n_tests++; if (sif.sleep_cnt !== 32'd100) begin n_fail++; $display("FAIL sleep_cnt_100: got %0d want 100", sif.sleep_cnt); end
        sif.irq = 4'b0001;
        tick(S);
        n_tests++; if (sif.pll_gate !== 1'b1) begin n_fail++; $display("FAIL ungate_early: got %b want 1", sif.pll_gate); end
        tick(1);
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL ungate: got %b want 0", sif.pll_gate); end
        n_tests++; if (sif.state !== 3'd3) begin n_fail++; $display("FAIL relock_state: got %0d want 3", sif.state); end
        sif.irq = '0;
        tick(R - 1);
        n_tests++; if (sif.wake !== 1'b0) begin n_fail++; $display("FAIL wake_early: got %b want 0", sif.wake); end
        n_tests++; if (sif.core_hold !== 1'b1) begin n_fail++; $display("FAIL hold_relock: got %b want 1", sif.core_hold); end
        tick(1);
        n_tests++; if (sif.wake !== 1'b1) begin n_fail++; $display("FAIL wake_pulse: got %b want 1", sif.wake); end
        n_tests++; if (sif.core_hold !== 1'b1) begin n_fail++; $display("FAIL hold_resume: got %b want 1", sif.core_hold); end
        tick(1);
        n_tests++; if (sif.wake !== 1'b0) begin n_fail++; $display("FAIL wake_width: got %b want 0", sif.wake); end
        n_tests++; if (sif.core_hold !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", sif.core_hold); end
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL run_after_wake: got %0d want 0", sif.state); end
        n_tests++; if (sif.sleep_cnt !== 32'd103) begin n_fail++; $display("FAIL sleep_cnt_total: got %0d want 103", sif.sleep_cnt); end
    endtask

    task automatic test_drain_glitch;
        logic seen_gate;
        seen_gate = 1'b0;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S + 1);
        for (int r = 0; r < 6; r++) begin
            sif.bus_idle = 1'b1;
            for (int k = 0; k < 9; k++) begin tick(1); seen_gate |= sif.pll_gate; end
            sif.bus_idle = 1'b0;
            tick(1);
            seen_gate |= sif.pll_gate;
        end
        n_tests++; if (seen_gate !== 1'b0) begin n_fail++; $display("FAIL glitch_gated: got %b want 0", seen_gate); end
        n_tests++; if (sif.state !== 3'd1) begin n_fail++; $display("FAIL glitch_state: got %0d want 1", sif.state); end
        sif.bus_idle = 1'b1;
        tick(D - 1);
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL idle_gate_early: got %b want 0", sif.pll_gate); end
        tick(1);
        n_tests++; if (sif.pll_gate !== 1'b1) begin n_fail++; $display("FAIL idle_gate: got %b want 1", sif.pll_gate); end
    endtask

    task automatic test_abort;
        int  wakes;
        logic bad;
        do_reset();
        sif.irq = 4'b0001;
        tick(S + 1);
        sif.wfi_req = 1'b1;
        tick(S);
        n_tests++; if (sif.wake !== 1'b0) begin n_fail++; $display("FAIL abort_wake_early: got %b want 0", sif.wake); end
        tick(1);
        n_tests++; if (sif.wake !== 1'b1) begin n_fail++; $display("FAIL abort_wake: got %b want 1", sif.wake); end
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", sif.state); end
        wakes = 0;
        bad   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (sif.wake === 1'b1) wakes++;
            bad |= sif.pll_gate | sif.core_hold | (sif.state != 3'd0);
        end
        n_tests++; if (wakes !== 0) begin n_fail++; $display("FAIL abort_rearm_held: got %0d wakes want 0", wakes); end
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL abort_left_run: got %b want 0", bad); end
        sif.wfi_req = 1'b0;
        tick(S + 2);
        sif.wfi_req = 1'b1;
        wakes = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (sif.wake === 1'b1) wakes++;
        end
        n_tests++; if (wakes !== 1) begin n_fail++; $display("FAIL abort_rearm: got %0d wakes want 1", wakes); end
    endtask

    task automatic test_irq_mask;
        int wakes;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S + 1 + D);
        sif.wfi_req = 1'b0;
        sif.irq = 4'b0100;
        tick(20);
        n_tests++; if (sif.pll_gate !== 1'b1) begin n_fail++; $display("FAIL masked_gate: got %b want 1", sif.pll_gate); end
        n_tests++; if (sif.state !== 3'd2) begin n_fail++; $display("FAIL masked_state: got %0d want 2", sif.state); end
        sif.irq_en = 4'b0101;
        tick(1);
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL unmask_ungate: got %b want 0", sif.pll_gate); end
        wakes = 0;
        for (int k = 0; k < R + 6; k++) begin
            tick(1);
            if (sif.wake === 1'b1) wakes++;
        end
        n_tests++; if (wakes !== 1) begin n_fail++; $display("FAIL unmask_wakes: got %0d want 1", wakes); end
        n_tests++; if (sif.core_hold !== 1'b0) begin n_fail++; $display("FAIL unmask_hold: got %b want 0", sif.core_hold); end
    endtask

    task automatic test_saturation;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S + 1 + D);
        sif.wfi_req = 1'b0;
        force dut.sleep_cnt_q = 32'hFFFF_FFF0;
        #2;
        release dut.sleep_cnt_q;
        tick(21);
        n_tests++; if (sif.sleep_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffffffff", sif.sleep_cnt); end
        tick(5);
        n_tests++; if (sif.sleep_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffffffff", sif.sleep_cnt); end
        n_tests++; if (sif.state !== 3'd2) begin n_fail++; $display("FAIL sat_state: got %0d want 2", sif.state); end
    endtask

    task automatic test_reset_gated;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S + 1 + D + 5);
        rst = 1'b1;
        #1;
        n_tests++; if (sif.pll_gate !== 1'b0) begin n_fail++; $display("FAIL rst_gated_gate: got %b want 0", sif.pll_gate); end
        n_tests++; if (sif.core_hold !== 1'b0) begin n_fail++; $display("FAIL rst_gated_hold: got %b want 0", sif.core_hold); end
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL rst_gated_state: got %0d want 0", sif.state); end
        n_tests++; if (sif.sleep_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_gated_cnt: got %0d want 0", sif.sleep_cnt); end
        sif.wfi_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        n_tests++; if (sif.state !== 3'd0) begin n_fail++; $display("FAIL rst_restart_state: got %0d want 0", sif.state); end
    endtask

`ifdef SLEEP_SEQ_LOCK_EN
    task automatic test_lock_early;
        do_reset();
        sif.wfi_req = 1'b1;
        tick(S + 1 + D);
        sif.wfi_req = 1'b0;
        sif.irq = 4'b0001;
        tick(S + 1);
        sif.irq = '0;
        tick(40);
        sif.pll_lock = 1'b1;
        tick(S);
        n_tests++; if (sif.wake !== 1'b0) begin n_fail++; $display("FAIL lock_wake_early: got %b want 0", sif.wake); end
        tick(1);
        n_tests++; if (sif.wake !== 1'b1) begin n_fail++; $display("FAIL lock_wake: got %b want 1", sif.wake); end
        sif.pll_lock = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_wake_path();
        test_drain_glitch();
        test_abort();
        test_irq_mask();
        test_saturation();
        test_reset_gated();
`ifdef SLEEP_SEQ_LOCK_EN
        test_lock_early();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
